sachen_regfile_mapper: RTL

Parametrised successor to the Sachen indexed-register mappers (8259 / JV001 / 74LS374N family). It provides an index/data register file at $4100/$4101 with a configurable CHR slot count, bank width and outer CHR bank. It also carries JV001-style protection accumulator readback and a CPU-cycle IRQ down-counter that none of the earlier Sachen blocks have. It sits in the mapper bank beside the other Sachen mappers and drives the shared tri-state mapper bus when `enable` is high.

---
 rtl/sachen_regfile_mapper.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sachen_regfile_mapper.sv
// Sachen-style index/data register mapper: CHR/PRG banking, protection accumulator
// readback and a CPU-cycle IRQ down-counter, driving the shared mapper bus when enabled.
module sachen_regfile_mapper #(
  parameter int CHR_SLOTS  = 4,
  parameter int CHR_BANK_W = 3,
  parameter int PRG_BANK_W = 3,
  parameter int IRQ_W      = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        enable,
  input  logic [31:0] flags,
  input  logic [15:0] prg_ain,
  input  logic        prg_read,
  input  logic        prg_write,
  input  logic [7:0]  prg_din,
  inout  wire  [21:0] prg_aout_b,
  inout  wire  [7:0]  prg_dout_b,
  inout  wire         prg_allow_b,
  input  logic [13:0] chr_ain,
  input  logic        chr_read,
  inout  wire  [21:0] chr_aout_b,
  inout  wire         chr_allow_b,
  inout  wire         vram_a10_b,
  inout  wire         vram_ce_b,
  inout  wire         irq_b,
  input  logic [15:0] audio_in,
  inout  wire  [15:0] audio_b,
  inout  wire  [15:0] flags_out_b
);

  logic                  sel_win, wr_en, wr_idx, wr_data, wr_strobe;
  logic                  irq_tick, irq_reload, bus_read;
  logic [3:0]            idx_q;
  logic [CHR_BANK_W-1:0] bank_q [8];
  logic [CHR_BANK_W-1:0] outer_q;
  logic [PRG_BANK_W-1:0] prg_bank_q;
  logic [1:0]            mirror_q, prot_ctl_q, irq_ctl_q;
  logic [5:0]            prot_in_q, acc_q, acc_d;
  logic [7:0]            latch_lo_q, latch_hi_q;
  logic [15:0]           latch_full;
  logic [IRQ_W-1:0]      latch, cnt_q, cnt_d;
  logic                  running_q, running_d, irq_pend_q, irq_pend_d;
  logic [21:0]           prg_addr, chr_addr;
  logic [7:0]            readback;
  logic                  vram_a10;

  assign sel_win    = (prg_ain[15:13] == 3'b010) && prg_ain[8];
  assign wr_en      = ce && enable && prg_write && sel_win;
  assign wr_idx     = wr_en && (prg_ain[1:0] == 2'b00);
  assign wr_data    = wr_en && (prg_ain[1:0] == 2'b01);
  assign wr_strobe  = wr_en && (prg_ain[1:0] == 2'b10);
  assign irq_tick   = ce && enable;
  assign irq_reload = wr_data && (idx_q == 4'hF);
  assign bus_read   = sel_win && prg_read;

  // Bits of the high latch byte beyond IRQ_W are simply never looked at.
  assign latch_full = {latch_hi_q, latch_lo_q};
  assign latch      = latch_full[IRQ_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q      <= '0;
      outer_q    <= '0;
      prg_bank_q <= '0;
      mirror_q   <= '0;
      prot_ctl_q <= '0;
      prot_in_q  <= '0;
      latch_lo_q <= '0;
      latch_hi_q <= '0;
      irq_ctl_q  <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      running_q  <= 1'b0;
      irq_pend_q <= 1'b0;
      for (int i = 0; i < 8; i++) bank_q[i] <= '0;
    end else begin
      if (wr_idx) idx_q <= prg_din[3:0];
      if (wr_data) begin
        for (int i = 0; i < 8; i++) begin
          if (idx_q == 4'(i)) bank_q[i] <= prg_din[CHR_BANK_W-1:0];
        end
        case (idx_q)
          4'd8:    outer_q    <= prg_din[CHR_BANK_W-1:0];
          4'd9:    prg_bank_q <= prg_din[PRG_BANK_W-1:0];
          4'd10:   mirror_q   <= prg_din[1:0];
          4'd11:   prot_ctl_q <= prg_din[1:0];
          4'd12:   prot_in_q  <= prg_din[5:0];
          4'd13:   latch_lo_q <= prg_din;
          4'd14:   latch_hi_q <= prg_din;
          4'd15:   irq_ctl_q  <= prg_din[1:0];
          default: ;
        endcase
      end
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      running_q  <= running_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (wr_strobe) begin
      if (prot_ctl_q[1])      acc_d = {acc_q[5:4], acc_q[3:0] + 4'd1};
      else if (prot_ctl_q[0]) acc_d = {prot_in_q[5:4], ~prot_in_q[3:0]};
      else                    acc_d = prot_in_q;
    end
  end

  // A control write restarts the counter and wins over any tick on the same edge.
  always_comb begin
    cnt_d      = cnt_q;
    running_d  = running_q;
    irq_pend_d = irq_pend_q;
    if (irq_reload) begin
      irq_pend_d = 1'b0;
      cnt_d      = latch;
      running_d  = prg_din[0];
    end else if (irq_tick && running_q) begin
      if (cnt_q == '0) begin
        irq_pend_d = 1'b1;
        if (irq_ctl_q[1]) cnt_d = latch;
        else              running_d = 1'b0;
      end else begin
        cnt_d = cnt_q - {{(IRQ_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign prg_addr = 22'({prg_bank_q, prg_ain[14:0]});
  assign readback = {2'b00, acc_q ^ (prot_ctl_q[0] ? 6'h30 : 6'h00)};

  generate
    if (CHR_SLOTS == 8) begin : g_chr8
      assign chr_addr = {2'b10, 20'({outer_q, bank_q[chr_ain[12:10]], chr_ain[9:0]})};
    end else begin : g_chr4
      assign chr_addr = {2'b10, 20'({outer_q, bank_q[{1'b0, chr_ain[12:11]}], chr_ain[10:0]})};
    end
  endgenerate

  always_comb begin
    case (mirror_q)
      2'd0:    vram_a10 = chr_ain[10];
      2'd1:    vram_a10 = chr_ain[11];
      2'd2:    vram_a10 = 1'b0;
      default: vram_a10 = 1'b1;
    endcase
  end

  assign prg_aout_b  = enable ? prg_addr : 'z;
  assign prg_dout_b  = enable ? readback : 'z;
  assign prg_allow_b = enable ? (prg_ain[15] && !prg_write) : 1'bz;
  assign chr_aout_b  = enable ? chr_addr : 'z;
  assign chr_allow_b = enable ? flags[15] : 1'bz;
  assign vram_a10_b  = enable ? vram_a10 : 1'bz;
  assign vram_ce_b   = enable ? chr_ain[13] : 1'bz;
  assign irq_b       = enable ? irq_pend_q : 1'bz;
  assign audio_b     = enable ? {1'b0, audio_in[15:1]} : 'z;
  assign flags_out_b = enable ? {14'd0, bus_read, 1'b0} : 'z;

  logic unused_ok;
  assign unused_ok = &{1'b0, chr_read, flags[31:16], flags[14:0], prg_ain[12:9],
                       prg_ain[7:2], audio_in[0], latch_full};

endmodule
